// File: rtl/pc_adder_constant.sv
// pc_adder_constant
//   Holds the PC increment used by the fetch-stage PC adder and forms the
//   sequential next-PC from it.
//
//   Ports
//     clk        : system clock, rising-edge active
//     rst_n      : asynchronous active-low reset
//     load_en    : request to write load_value into the increment register
//     load_value : new increment value (must be aligned to be accepted)
//     lock       : sets the sticky write lock on a clock edge
//     stall      : masks the effective increment to zero (PC holds)
//     pc_in      : current program counter
//     constant   : effective increment presented to the PC adder
//     pc_next    : pc_in + constant, modulo 2^WIDTH
//     carry      : carry-out of the pc_next addition
//     locked     : state of the sticky lock bit
//     load_err   : one-cycle pulse after a refused write
//
//   Interface timing: there is no valid/ready handshake. A write is a
//   single-cycle request on load_en, resolved at the next rising edge; the
//   accepted value shows on constant in the following cycle, and a refusal
//   shows as load_err high for exactly that following cycle.
module pc_adder_constant #(
    parameter int unsigned           WIDTH       = 16,
    parameter logic [WIDTH-1:0]      DEFAULT_INC = WIDTH'(2),
    parameter logic [WIDTH-1:0]      ALIGN_MASK  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             lock,
    input  logic             stall,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] constant,
    output logic [WIDTH-1:0] pc_next,
    output logic             carry,
    output logic             locked,
    output logic             load_err
);

    logic [WIDTH-1:0] inc_reg;
    logic             locked_q;
    logic             load_err_q;
    logic             aligned;
    logic             write_ok;
    logic             write_bad;
    logic [WIDTH:0]   sum;

    // Acceptance uses the pre-edge lock state, so a write and a lock on the
    // same edge both take effect.
    assign aligned   = ((load_value & ALIGN_MASK) == '0);
    assign write_ok  = load_en && !locked_q && aligned;
    assign write_bad = load_en && !write_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_reg    <= DEFAULT_INC;
            locked_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            if (write_ok) begin
                inc_reg <= load_value;
            end
            // Sticky: only reset clears the lock.
            if (lock) begin
                locked_q <= 1'b1;
            end
            load_err_q <= write_bad;
        end
    end

    // stall only masks the output; the stored increment is untouched.
    assign constant = stall ? '0 : inc_reg;
    assign sum      = {1'b0, pc_in} + {1'b0, constant};
    assign pc_next  = sum[WIDTH-1:0];
    assign carry    = sum[WIDTH];
    assign locked   = locked_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_pc_adder_constant.sv
module tb_pc_adder_constant;

    localparam int W  = 16;
    localparam int EW = 2 * W + 3;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_en = 1'b0;
    logic [W-1:0]  load_value = '0;
    logic          lock = 1'b0;
    logic          stall = 1'b0;
    logic [W-1:0]  pc_in = '0;
    logic [W-1:0]  constant;
    logic [W-1:0]  pc_next;
    logic          carry;
    logic          locked;
    logic          load_err;

    always #5 clk = ~clk;

    pc_adder_constant #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_en(load_en),
        .load_value(load_value),
        .lock(lock),
        .stall(stall),
        .pc_in(pc_in),
        .constant(constant),
        .pc_next(pc_next),
        .carry(carry),
        .locked(locked),
        .load_err(load_err)
    );

    // ---------------- scoreboard ----------------
    // Expected word: {constant, pc_next, carry, locked, load_err}
    logic [EW-1:0] exp_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            step_no = 0;
    int            chk_no  = 0;

    function automatic logic [EW-1:0] mk(input logic [W-1:0] c, input logic [W-1:0] n,
                                         input logic cy, input logic l, input logic e);
        return {c, n, cy, l, e};
    endfunction

    // Monitor: each cycle with a pending expectation, sample mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] exp_v;
            logic [EW-1:0] act_v;
            exp_v = exp_q.pop_front();
            act_v = {constant, pc_next, carry, locked, load_err};
            chk_no++;
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL step%0d: got const=%h next=%h carry=%b locked=%b err=%b, want const=%h next=%h carry=%b locked=%b err=%b",
                         chk_no, act_v[EW-1 -: W], act_v[W+2 +: W], act_v[2], act_v[1], act_v[0],
                         exp_v[EW-1 -: W], exp_v[W+2 +: W], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic rn, input logic le, input logic [W-1:0] lv,
                        input logic lk, input logic st, input logic [W-1:0] pc,
                        input logic [EW-1:0] exp_v);
        @(posedge clk);
        #1;
        rst_n      = rn;
        load_en    = le;
        load_value = lv;
        lock       = lk;
        stall      = st;
        pc_in      = pc;
        exp_q.push_back(exp_v);
        step_no++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #100;
        rst_n = 1'b1;

        //   rst  le  value    lk  st  pc_in        const     next      cy  L  E
        step(1, 0, 16'h0000, 0, 0, 16'h0100, mk(16'h0002, 16'h0102, 0, 0, 0)); // reset values
        step(1, 0, 16'h0000, 0, 0, 16'hFFFF, mk(16'h0002, 16'h0001, 1, 0, 0)); // wrap
        step(1, 1, 16'h0004, 0, 0, 16'h0010, mk(16'h0002, 16'h0012, 0, 0, 0)); // load 4 issued
        step(1, 0, 16'h0000, 0, 0, 16'h0010, mk(16'h0004, 16'h0014, 0, 0, 0)); // 4 visible
        step(1, 1, 16'h0003, 0, 0, 16'h0020, mk(16'h0004, 16'h0024, 0, 0, 0)); // misaligned issued
        step(1, 0, 16'h0000, 0, 0, 16'h0020, mk(16'h0004, 16'h0024, 0, 0, 1)); // err pulse
        step(1, 0, 16'h0000, 0, 0, 16'h0020, mk(16'h0004, 16'h0024, 0, 0, 0)); // pulse gone
        step(1, 1, 16'h0006, 1, 0, 16'h0030, mk(16'h0004, 16'h0034, 0, 0, 0)); // load+lock same edge
        step(1, 0, 16'h0000, 0, 0, 16'h0030, mk(16'h0006, 16'h0036, 0, 1, 0)); // 6 written, locked
        step(1, 1, 16'h0008, 0, 0, 16'h0040, mk(16'h0006, 16'h0046, 0, 1, 0)); // locked write issued
        step(1, 0, 16'h0000, 0, 0, 16'h0040, mk(16'h0006, 16'h0046, 0, 1, 1)); // refused
        step(1, 0, 16'h0000, 0, 0, 16'h0040, mk(16'h0006, 16'h0046, 0, 1, 0)); // pulse gone
        step(0, 0, 16'h0000, 0, 0, 16'h0050, mk(16'h0002, 16'h0052, 0, 0, 0)); // async reset, mid-cycle
        step(1, 0, 16'h0000, 0, 0, 16'h0050, mk(16'h0002, 16'h0052, 0, 0, 0)); // released
        step(1, 0, 16'h0000, 0, 1, 16'h1234, mk(16'h0000, 16'h1234, 0, 0, 0)); // stall
        step(1, 0, 16'h0000, 0, 0, 16'h1234, mk(16'h0002, 16'h1236, 0, 0, 0)); // unstall
        step(1, 1, 16'h0000, 0, 0, 16'h0060, mk(16'h0002, 16'h0062, 0, 0, 0)); // load 0
        step(1, 0, 16'h0000, 0, 0, 16'h0060, mk(16'h0000, 16'h0060, 0, 0, 0)); // PC holds
        step(1, 1, 16'h000A, 0, 1, 16'h0070, mk(16'h0000, 16'h0070, 0, 0, 0)); // load during stall
        step(1, 0, 16'h0000, 0, 0, 16'h0070, mk(16'h000A, 16'h007A, 0, 0, 0)); // load took effect
        step(1, 0, 16'h0000, 0, 0, 16'hFFF8, mk(16'h000A, 16'h0002, 1, 0, 0)); // wrap with 10
        step(1, 0, 16'h0000, 1, 0, 16'h0080, mk(16'h000A, 16'h008A, 0, 0, 0)); // lock alone
        step(1, 1, 16'h0002, 0, 0, 16'h0080, mk(16'h000A, 16'h008A, 0, 1, 0)); // locked write issued
        step(1, 0, 16'h0000, 0, 0, 16'h0080, mk(16'h000A, 16'h008A, 0, 1, 1)); // refused

        // Drain: bounded wait for the monitor to consume everything.
        @(posedge clk);
        #1;
        load_en = 1'b0;
        lock    = 1'b0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0 || chk_no != step_no) begin
            n_fail++;
            $display("FAIL drain: checked %0d, issued %0d, pending %0d", chk_no, step_no, exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, checked %0d of %0d", chk_no, step_no);
        $fatal(1, "timeout");
    end

endmodule
